// File: rtl/inst_fetch_pkg.sv
// Shared constants, state encoding and buffer entry layout for the fetch unit.
package inst_fetch_pkg;

   localparam logic [31:0] INST_NOP  = 32'h0000_0013;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // IDLE only exists for the single cycle after reset release.
   // WAIT and DISCARD both mean one request is outstanding.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_WAIT    = 2'd2,
      S_DISCARD = 2'd3
   } fetch_state_e;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } fetch_entry_t;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous instruction buffer with flush; the head entry is visible combinationally.
module inst_fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   // A pop frees the slot a same-cycle push needs, so a full buffer can still accept.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);

   // Pointer and occupancy bookkeeping; flush discards everything buffered.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; an entry is only read after it has been written.
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch front end: owns the PC, runs the memory handshake and feeds decode from a small buffer.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        stall_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      req_addr_q, req_addr_d;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;
   logic             outstanding;
   logic             slot_ok;
   logic             granted;

   // A request may only go out if its response is guaranteed a buffer slot.
   assign outstanding = (state_q == S_WAIT) || (state_q == S_DISCARD);
   assign slot_ok     = (fifo_count + CNT_W'(outstanding)) < CNT_W'(FIFO_DEPTH);
   assign mem_req_o   = (state_q == S_REQ) && slot_ok;
   assign mem_addr_o  = (state_q == S_REQ) ? pc_q : req_addr_q;
   assign granted     = mem_req_o && mem_gnt_i;

   // Next state, pc and push decision; a redirect retargets the pc over everything else.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      fifo_push  = 1'b0;
      unique case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (granted) begin
               req_addr_d = pc_q;
               pc_d       = pc_q + 32'd4;
               state_d    = jump_flag_i ? S_DISCARD : S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid_i) begin
               fifo_push = !jump_flag_i;
               state_d   = S_REQ;
            end else if (jump_flag_i) begin
               state_d = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (mem_rvalid_i) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
      if (jump_flag_i) pc_d = word_align(jump_addr_i);
   end

   // FSM, pc and outstanding-request address registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= ZERO_WORD;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   assign push_entry = '{addr: req_addr_q, inst: mem_rdata_i};
   assign fifo_pop   = !fifo_empty && !stall_i && !jump_flag_i;

   inst_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (jump_flag_i),
      .push_i      (fifo_push),
      .push_data_i (push_entry),
      .pop_i       (fifo_pop),
      .head_o      (head_entry),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign inst_valid_o = !fifo_empty;
   assign inst_o       = fifo_empty ? INST_NOP  : head_entry.inst;
   assign inst_addr_o  = fifo_empty ? ZERO_WORD : head_entry.addr;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: the bench plays instruction memory and tracks the expected
// fetch stream as a queue of {addr, inst} pairs.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam logic [31:0] HI_RESET_PC = 32'hFFFF_FFF8;
   localparam int unsigned FIFO_DEPTH  = 2;
   localparam logic [31:0] NOP         = 32'h0000_0013;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
   } exp_entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_gnt_i, mem_rvalid_i, jump_flag_i, stall_i;
   logic [31:0] mem_rdata_i, jump_addr_i;
   logic        mem_req_o, inst_valid_o;
   logic [31:0] mem_addr_o, inst_o, inst_addr_o;
   logic        hi_mem_req_o, hi_inst_valid_o;
   logic [31:0] hi_mem_addr_o, hi_inst_o, hi_inst_addr_o;

   int total = 0;
   int bad   = 0;

   // Reference model state
   exp_entry_t  exp_q[$];
   bit          outstanding;
   bit          out_flushed;
   logic [31:0] out_addr;
   logic [31:0] exp_pc;
   logic [31:0] granted_q[$];
   logic [31:0] hi_granted_q[$];
   logic [31:0] resp_q[$];

   // Stimulus knobs (percent probabilities)
   int          p_gnt, p_rvalid, p_stall, p_jump;
   bit          force_jump;
   logic [31:0] force_addr;
   bit          stray_rvalid;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) u_dut (
      .clk (clk), .rst (rst),
      .mem_req_o (mem_req_o), .mem_addr_o (mem_addr_o), .mem_gnt_i (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i), .mem_rdata_i (mem_rdata_i),
      .jump_flag_i (jump_flag_i), .jump_addr_i (jump_addr_i), .stall_i (stall_i),
      .inst_valid_o (inst_valid_o), .inst_o (inst_o), .inst_addr_o (inst_addr_o)
   );

   inst_fetch #(.RESET_PC(HI_RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) u_dut_hi (
      .clk (clk), .rst (rst),
      .mem_req_o (hi_mem_req_o), .mem_addr_o (hi_mem_addr_o), .mem_gnt_i (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i), .mem_rdata_i (mem_rdata_i),
      .jump_flag_i (jump_flag_i), .jump_addr_i (jump_addr_i), .stall_i (stall_i),
      .inst_valid_o (hi_inst_valid_o), .inst_o (hi_inst_o), .inst_addr_o (hi_inst_addr_o)
   );

   task automatic zero_inputs();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      jump_flag_i  = 1'b0;
      jump_addr_i  = 32'h0;
      stall_i      = 1'b0;
   endtask

   task automatic set_knobs(input int g, input int r, input int s, input int j);
      p_gnt    = g;
      p_rvalid = r;
      p_stall  = s;
      p_jump   = j;
   endtask

   task automatic model_reset();
      exp_q.delete();
      granted_q.delete();
      hi_granted_q.delete();
      resp_q.delete();
      outstanding  = 1'b0;
      out_flushed  = 1'b0;
      out_addr     = 32'h0;
      exp_pc       = RESET_PC;
      force_jump   = 1'b0;
      stray_rvalid = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      zero_inputs();
      repeat (2) @(negedge clk);
      model_reset();
      rst = 1'b0;
   endtask

   // One clock: observe at the falling edge, compare with the model, drive the
   // next inputs, then advance the model to what the rising edge must produce.
   task automatic cycle();
      bit          exp_req, gnt, rvalid, stall, jump, do_pop;
      logic [31:0] jaddr, rdata;
      @(negedge clk);
      exp_req = !outstanding && (exp_q.size() < FIFO_DEPTH);
      total++;
      if (mem_req_o !== exp_req) begin
         bad++;
         $display("FAIL mem_req t=%0t got=%b exp=%b", $time, mem_req_o, exp_req);
      end
      if (exp_req) begin
         total++;
         if (mem_addr_o !== exp_pc) begin
            bad++;
            $display("FAIL mem_addr t=%0t got=%h exp=%h", $time, mem_addr_o, exp_pc);
         end
      end
      total++;
      if (inst_valid_o !== (exp_q.size() != 0)) begin
         bad++;
         $display("FAIL inst_valid t=%0t got=%b exp=%b", $time, inst_valid_o, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
         total++;
         if (inst_addr_o !== exp_q[0].addr || inst_o !== exp_q[0].inst) begin
            bad++;
            $display("FAIL head t=%0t got=%h/%h exp=%h/%h", $time, inst_addr_o, inst_o,
                     exp_q[0].addr, exp_q[0].inst);
         end
      end else begin
         total++;
         if (inst_o !== NOP || inst_addr_o !== 32'h0) begin
            bad++;
            $display("FAIL idle_out t=%0t got=%h/%h exp=00000000/%h", $time, inst_addr_o, inst_o, NOP);
         end
      end

      gnt    = mem_req_o && ($urandom_range(99) < p_gnt);
      rvalid = outstanding ? ($urandom_range(99) < p_rvalid) : stray_rvalid;
      rdata  = $urandom;
      stall  = $urandom_range(99) < p_stall;
      jump   = force_jump || ($urandom_range(99) < p_jump);
      jaddr  = force_jump ? force_addr :
               (($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);

      if (mem_req_o && gnt)    granted_q.push_back(mem_addr_o);
      if (hi_mem_req_o && gnt) hi_granted_q.push_back(hi_mem_addr_o);
      if (outstanding && rvalid) resp_q.push_back(rdata);

      mem_gnt_i    = gnt;
      mem_rvalid_i = rvalid;
      mem_rdata_i  = rdata;
      stall_i      = stall;
      jump_flag_i  = jump;
      jump_addr_i  = jaddr;

      if (jump) begin
         exp_q.delete();
         if (outstanding) begin
            if (rvalid) outstanding = 1'b0;
            else        out_flushed = 1'b1;
         end
         if (mem_req_o && gnt) begin
            outstanding = 1'b1;
            out_flushed = 1'b1;
         end
         exp_pc = {jaddr[31:2], 2'b00};
      end else begin
         do_pop = (exp_q.size() != 0) && !stall;
         if (do_pop) void'(exp_q.pop_front());
         if (outstanding && rvalid) begin
            if (!out_flushed) exp_q.push_back('{addr: out_addr, inst: rdata});
            outstanding = 1'b0;
         end
         if (mem_req_o && gnt) begin
            outstanding = 1'b1;
            out_flushed = 1'b0;
            out_addr    = exp_pc;
            exp_pc      = exp_pc + 32'd4;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (mem_req_o !== 1'b0 || hi_mem_req_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_req got=%b/%b exp=0/0", mem_req_o, hi_mem_req_o);
      end
      total++;
      if (mem_addr_o !== 32'h0 || hi_mem_addr_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_addr got=%h/%h exp=0/0", mem_addr_o, hi_mem_addr_o);
      end
      total++;
      if (inst_valid_o !== 1'b0 || hi_inst_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid got=%b/%b exp=0/0", inst_valid_o, hi_inst_valid_o);
      end
      total++;
      if (inst_o !== NOP || inst_addr_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_inst got=%h/%h exp=%h/0", inst_o, inst_addr_o, NOP);
      end
      model_reset();
      rst = 1'b0;
      set_knobs(0, 0, 0, 0);
      cycle();
   endtask

   task automatic test_basic_fetch();
      logic [31:0] first_data;
      apply_reset();
      set_knobs(100, 100, 0, 0);
      repeat (3) cycle();
      first_data = (resp_q.size() != 0) ? resp_q[0] : 32'hDEAD_BEEF;
      total++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== RESET_PC || inst_o !== first_data) begin
         bad++;
         $display("FAIL first_inst got=%b/%h/%h exp=1/%h/%h", inst_valid_o, inst_addr_o, inst_o,
                  RESET_PC, first_data);
      end
      repeat (2) cycle();
      total++;
      if (granted_q.size() < 3 || granted_q[0] !== 32'h0 || granted_q[1] !== 32'h4 ||
          granted_q[2] !== 32'h8) begin
         bad++;
         $display("FAIL fetch_addrs got=%0d grants exp=00000000,00000004,00000008", granted_q.size());
      end
   endtask

   task automatic test_stall();
      apply_reset();
      set_knobs(100, 100, 100, 0);
      repeat (6) cycle();
      total++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== RESET_PC || mem_req_o !== 1'b0) begin
         bad++;
         $display("FAIL stall_hold got=%b/%h/req%b exp=1/%h/req0", inst_valid_o, inst_addr_o,
                  mem_req_o, RESET_PC);
      end
      total++;
      if (granted_q.size() != FIFO_DEPTH) begin
         bad++;
         $display("FAIL stall_grants got=%0d exp=%0d", granted_q.size(), FIFO_DEPTH);
      end
      set_knobs(0, 100, 0, 0);
      cycle();
      cycle();
      total++;
      if (inst_addr_o !== RESET_PC + 32'd4) begin
         bad++;
         $display("FAIL drain_second got=%h exp=%h", inst_addr_o, RESET_PC + 32'd4);
      end
      cycle();
      total++;
      if (inst_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL drain_empty got=%b exp=0", inst_valid_o);
      end
   endtask

   task automatic test_jump_in_wait();
      apply_reset();
      set_knobs(100, 0, 0, 0);
      cycle();
      set_knobs(0, 0, 0, 0);
      force_jump = 1'b1;
      force_addr = 32'h0000_0103;
      cycle();
      force_jump = 1'b0;
      cycle();
      set_knobs(0, 100, 0, 0);
      cycle();
      cycle();
      total++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0100 || inst_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL jump_wait got=req%b/%h/v%b exp=req1/00000100/v0", mem_req_o, mem_addr_o,
                  inst_valid_o);
      end
   endtask

   task automatic test_jump_coincident();
      apply_reset();
      set_knobs(100, 0, 0, 0);
      cycle();
      set_knobs(0, 100, 0, 0);
      force_jump = 1'b1;
      force_addr = 32'h0000_0200;
      cycle();
      force_jump = 1'b0;
      cycle();
      total++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0200 || inst_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL jump_rvalid got=req%b/%h/v%b exp=req1/00000200/v0", mem_req_o, mem_addr_o,
                  inst_valid_o);
      end
      set_knobs(100, 0, 0, 0);
      force_jump = 1'b1;
      force_addr = 32'h0000_0300;
      cycle();
      force_jump = 1'b0;
      cycle();
      total++;
      if (mem_req_o !== 1'b0) begin
         bad++;
         $display("FAIL jump_gnt_discard got=req%b exp=req0", mem_req_o);
      end
      set_knobs(100, 100, 0, 0);
      cycle();
      cycle();
      total++;
      if (mem_addr_o !== 32'h0000_0300 || inst_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL jump_gnt_after got=%h/v%b exp=00000300/v0", mem_addr_o, inst_valid_o);
      end
   endtask

   task automatic test_reset_pc_wrap();
      apply_reset();
      set_knobs(100, 100, 0, 0);
      repeat (3) cycle();
      total++;
      if (hi_inst_valid_o !== 1'b1 || hi_inst_addr_o !== HI_RESET_PC) begin
         bad++;
         $display("FAIL hi_first got=%b/%h exp=1/%h", hi_inst_valid_o, hi_inst_addr_o, HI_RESET_PC);
      end
      repeat (2) cycle();
      total++;
      if (hi_granted_q.size() < 3 || hi_granted_q[0] !== 32'hFFFF_FFF8 ||
          hi_granted_q[1] !== 32'hFFFF_FFFC || hi_granted_q[2] !== 32'h0000_0000) begin
         bad++;
         $display("FAIL pc_wrap got=%0d grants exp=FFFFFFF8,FFFFFFFC,00000000", hi_granted_q.size());
      end
   endtask

   task automatic test_reset_in_wait();
      apply_reset();
      set_knobs(100, 0, 0, 0);
      cycle();
      @(posedge clk);
      #2;
      rst = 1'b1;
      zero_inputs();
      #1;
      total++;
      if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || inst_valid_o !== 1'b0 ||
          inst_o !== NOP || inst_addr_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_wait got=req%b/%h/v%b/%h/%h", mem_req_o, mem_addr_o, inst_valid_o,
                  inst_o, inst_addr_o);
      end
      @(negedge clk);
      model_reset();
      rst          = 1'b0;
      mem_rvalid_i = 1'b1;
      stray_rvalid = 1'b1;
      set_knobs(0, 0, 0, 0);
      repeat (2) cycle();
      stray_rvalid = 1'b0;
      cycle();
      total++;
      if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== RESET_PC) begin
         bad++;
         $display("FAIL late_rvalid got=v%b/req%b/%h exp=v0/req1/%h", inst_valid_o, mem_req_o,
                  mem_addr_o, RESET_PC);
      end
      set_knobs(100, 100, 0, 0);
      repeat (4) cycle();
   endtask

   task automatic test_random();
      apply_reset();
      set_knobs(60, 50, 30, 5);
      repeat (2000) cycle();
      set_knobs(70, 70, 0, 0);
      repeat (30) cycle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      zero_inputs();
      model_reset();
      set_knobs(0, 0, 0, 0);
      force_addr = 32'h0;
      test_reset();
      test_basic_fetch();
      test_stall();
      test_jump_in_wait();
      test_jump_coincident();
      test_reset_pc_wrap();
      test_reset_in_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
